// File: rtl/ps2_byte_receiver_if.sv
// Line-side and byte-side signals of the PS/2 receive stage.
// The master drives the raw lines and enable; the slave is the receiver.
interface ps2_byte_receiver_if;
  logic       PS2_CLK_IN;
  logic       PS2_DATA_IN;
  logic       RX_ENABLE;
  logic [7:0] BYTE_OUT;
  logic       BYTE_READY;
  logic       RX_ERROR;
  logic [1:0] ERR_CODE;
  logic       BUSY;

  modport master (
    output PS2_CLK_IN, PS2_DATA_IN, RX_ENABLE,
    input  BYTE_OUT, BYTE_READY, RX_ERROR, ERR_CODE, BUSY
  );

  modport slave (
    input  PS2_CLK_IN, PS2_DATA_IN, RX_ENABLE,
    output BYTE_OUT, BYTE_READY, RX_ERROR, ERR_CODE, BUSY
  );
endinterface

// File: rtl/ps2_byte_receiver.sv
// PS/2 device->host receiver: sync + glitch filter + 11-bit frame FSM with timeout.
// Latency: raw stop-bit falling edge to BYTE_READY is FILTER_LEN+4 cycles; no backpressure.
module ps2_byte_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input logic              CLK,
  input logic              RESET,
  ps2_byte_receiver_if.slave rx
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Synchronisers and clock filter
  logic          clk_meta, clk_sync;
  logic          data_meta, data_sync;
  logic [FW-1:0] filt_cnt;
  logic          clk_filt, clk_filt_q;
  logic          sample;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      clk_meta   <= 1'b1;
      clk_sync   <= 1'b1;
      data_meta  <= 1'b1;
      data_sync  <= 1'b1;
      filt_cnt   <= '0;
      clk_filt   <= 1'b1;
      clk_filt_q <= 1'b1;
      sample     <= 1'b0;
    end else begin
      clk_meta   <= rx.PS2_CLK_IN;
      clk_sync   <= clk_meta;
      data_meta  <= rx.PS2_DATA_IN;
      data_sync  <= data_meta;
      clk_filt_q <= clk_filt;
      // Registered falling edge keeps the FSM off the filter's combinational path.
      sample     <= clk_filt_q & ~clk_filt;
      if (clk_sync == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Frame FSM and datapath
  state_t        state, state_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic          par_bit, par_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic [7:0]    byte_q, byte_nxt;
  logic          rdy_q, rdy_nxt;
  logic          err_q, err_nxt;
  logic [1:0]    code_q, code_nxt;
  logic          timeout_hit;

  assign timeout_hit = (state != IDLE) && !sample && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!rx.RX_ENABLE || timeout_hit) begin
      state_nxt = IDLE;
    end else if (sample) begin
      unique case (state)
        IDLE:    if (!data_sync) state_nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    par_nxt     = par_bit;
    byte_nxt    = byte_q;
    rdy_nxt     = 1'b0;
    err_nxt     = 1'b0;
    code_nxt    = code_q;
    if (state == IDLE)                 tcnt_nxt = '0;
    else if (tcnt != TW'(TIMEOUT_CYCLES)) tcnt_nxt = tcnt + 1'b1;
    else                               tcnt_nxt = tcnt;

    if (!rx.RX_ENABLE) begin
      tcnt_nxt = '0;
    end else if (timeout_hit) begin
      tcnt_nxt = '0;
      err_nxt  = 1'b1;
      code_nxt = 2'b11;
    end else if (sample) begin
      tcnt_nxt = '0;
      unique case (state)
        IDLE: begin
          if (!data_sync) begin
            bit_cnt_nxt = '0;
            shreg_nxt   = '0;
          end
        end
        DATA: begin
          shreg_nxt = {data_sync, shreg[7:1]};
          if (bit_cnt != 3'd7) bit_cnt_nxt = bit_cnt + 3'd1;
        end
        PARITY: par_nxt = data_sync;
        STOP: begin
          // Framing error outranks a parity error.
          if (!data_sync) begin
            err_nxt  = 1'b1;
            code_nxt = 2'b10;
          end else if (^{shreg, par_bit}) begin
            rdy_nxt  = 1'b1;
            byte_nxt = shreg;
            code_nxt = 2'b00;
          end else begin
            err_nxt  = 1'b1;
            code_nxt = 2'b01;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      shreg   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
      tcnt    <= '0;
      byte_q  <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      par_bit <= par_nxt;
      tcnt    <= tcnt_nxt;
      byte_q  <= byte_nxt;
      rdy_q   <= rdy_nxt;
      err_q   <= err_nxt;
      code_q  <= code_nxt;
    end
  end

  assign rx.BYTE_OUT   = byte_q;
  assign rx.BYTE_READY = rdy_q;
  assign rx.RX_ERROR   = err_q;
  assign rx.ERR_CODE   = code_q;
  assign rx.BUSY       = (state != IDLE);

endmodule

// File: tb/tb_ps2_byte_receiver.sv
// Randomised PS/2 frame bench with an event-queue reference model of the receiver.
module tb_ps2_byte_receiver;
  localparam int FL  = 8;
  localparam int TO  = 20000;
  localparam int LAT = FL + 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  ps2_byte_receiver_if bus();

  ps2_byte_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .CLK   (clk),
    .RESET (rst),
    .rx    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    bit         is_err;
    logic [7:0] b;
    logic [1:0] code;
  } ev_t;

  ev_t        q[$];
  logic [7:0] m_byte = '0;
  logic [1:0] m_code = '0;
  int vectors = 0, miscompares = 0, nprint = 0;
  int n_rdy = 0, n_err = 0, last_rdy = 0, last_err = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected strobes live in a time-stamped queue; held outputs follow the last event.
  task automatic compare_loop();
    ev_t ev;
    bit  e_rdy, e_err;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        m_byte = '0;
        m_code = '0;
      end else begin
        e_rdy = 1'b0;
        e_err = 1'b0;
        if (q.size() > 0 && q[0].at == cyc) begin
          ev = q.pop_front();
          if (ev.is_err) begin
            e_err  = 1'b1;
            m_code = ev.code;
          end else begin
            e_rdy  = 1'b1;
            m_byte = ev.b;
            m_code = 2'b00;
          end
        end
        vectors++;
        if (bus.BYTE_READY !== e_rdy || bus.RX_ERROR !== e_err ||
            bus.BYTE_OUT !== m_byte || bus.ERR_CODE !== m_code) begin
          miscompares++;
          if (nprint < 20) begin
            nprint++;
            $display("FAIL cycle %0d: rdy %b/%b err %b/%b byte %h/%h code %b/%b (got/expected)",
                     cyc, bus.BYTE_READY, e_rdy, bus.RX_ERROR, e_err,
                     bus.BYTE_OUT, m_byte, bus.ERR_CODE, m_code);
          end
        end
        if (bus.BYTE_READY === 1'b1) begin n_rdy++; last_rdy = cyc; end
        if (bus.RX_ERROR === 1'b1)   begin n_err++; last_err = cyc; end
      end
    end
  endtask

  // act: 1 = drop RX_ENABLE, 2 = pulse RESET, during the low phase of bit act_bit.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                            input int nbits, input int act_bit, input int act,
                            output int last_fall);
    logic [10:0] bits;
    bit          aborted;
    int          hi, lo, g;
    ev_t         ev;
    bits      = {stp, par, b, 1'b0};
    aborted   = 1'b0;
    last_fall = 0;
    for (int i = 0; i < nbits; i++) begin
      hi = $urandom_range(40, 20);
      lo = $urandom_range(40, 20);
      bus.PS2_DATA_IN = bits[i];
      if (hi >= 25 && $urandom_range(3, 0) == 0) begin
        g = $urandom_range(FL - 2, 1);
        tick(10);
        bus.PS2_CLK_IN = 1'b0;
        tick(g);
        bus.PS2_CLK_IN = 1'b1;
        tick(hi - 10 - g);
      end else begin
        tick(hi);
      end
      bus.PS2_CLK_IN = 1'b0;
      last_fall = cyc;
      if (i == 10 && !aborted) begin
        ev.at = last_fall + LAT;
        ev.b  = b;
        if (!stp) begin
          ev.is_err = 1'b1; ev.code = 2'b10;
        end else if (($countones(b) + int'(par)) % 2 == 1) begin
          ev.is_err = 1'b0; ev.code = 2'b00;
        end else begin
          ev.is_err = 1'b1; ev.code = 2'b01;
        end
        q.push_back(ev);
      end
      if (i == act_bit) begin
        tick(FL + 6);
        aborted = 1'b1;
        if (act == 1) begin
          bus.RX_ENABLE = 1'b0;
          tick(lo - FL - 6);
        end else begin
          rst = 1'b1;
          tick(2);
          rst = 1'b0;
          tick(lo - FL - 8);
        end
      end else begin
        tick(lo);
      end
      bus.PS2_CLK_IN = 1'b1;
    end
    bus.PS2_DATA_IN = 1'b1;
    tick($urandom_range(60, 30));
  endtask

  task automatic run_stim();
    int         lf, r0, e0;
    logic       busy_seen;
    logic [7:0] b;
    logic       par, stp;
    ev_t        ev;

    tick(3);
    rst = 1'b0;
    tick(2);
    check("reset_outputs", {bus.BYTE_OUT, bus.BYTE_READY, bus.RX_ERROR, bus.ERR_CODE, bus.BUSY}, 0);

    send_frame(8'hFA, 1'b1, 1'b1, 11, -1, 0, lf);
    check("t1_byte", bus.BYTE_OUT, 8'hFA);
    check("t1_code", bus.ERR_CODE, 2'b00);
    check("t1_busy", bus.BUSY, 1'b0);
    check("t1_latency", last_rdy - lf, 12);
    check("t1_ready_count", n_rdy, 1);

    send_frame(8'hAA, 1'b0, 1'b1, 11, -1, 0, lf);
    check("t2_code", bus.ERR_CODE, 2'b01);
    check("t2_byte_held", bus.BYTE_OUT, 8'hFA);
    check("t2_err_latency", last_err - lf, 12);

    send_frame(8'h55, 1'b1, 1'b0, 11, -1, 0, lf);
    check("t3_code", bus.ERR_CODE, 2'b10);
    r0 = n_rdy;
    e0 = n_err;
    bus.PS2_CLK_IN = 1'b0;
    tick(7);
    bus.PS2_CLK_IN = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      busy_seen = busy_seen | bus.BUSY;
    end
    check("t3_glitch_busy", busy_seen, 1'b0);
    check("t3_glitch_strobes", n_rdy + n_err, r0 + e0);

    send_frame(8'h3C, 1'b1, 1'b1, 5, -1, 0, lf);
    ev.at = lf + LAT + TO; ev.is_err = 1'b1; ev.b = '0; ev.code = 2'b11;
    q.push_back(ev);
    tick(TO + 60);
    check("t4_code", bus.ERR_CODE, 2'b11);
    check("t4_timeout_cycle", last_err - lf, 20012);
    send_frame(8'h08, 1'b0, 1'b1, 11, -1, 0, lf);
    check("t4_byte", bus.BYTE_OUT, 8'h08);

    r0 = n_rdy;
    send_frame(8'hF4, 1'b0, 1'b1, 11, 6, 1, lf);
    check("t5_busy_disabled", bus.BUSY, 1'b0);
    check("t5_no_strobe", n_rdy, r0);
    bus.RX_ENABLE = 1'b1;
    tick(5);
    send_frame(8'hF4, 1'b0, 1'b1, 11, -1, 0, lf);
    check("t5_byte", bus.BYTE_OUT, 8'hF4);

    send_frame(8'hFA, 1'b1, 1'b1, 11, 8, 2, lf);
    check("t6_reset_outputs", {bus.BYTE_OUT, bus.ERR_CODE, bus.BUSY}, 0);
    r0 = n_rdy;
    send_frame(8'h00, 1'b1, 1'b1, 11, -1, 0, lf);
    check("t6_ready", n_rdy, r0 + 1);
    check("t6_code", bus.ERR_CODE, 2'b00);

    for (int k = 0; k < 20; k++) begin
      b   = 8'($urandom);
      par = ~(^b);
      if ($urandom_range(4, 0) == 0) par = ~par;
      stp = ($urandom_range(9, 0) != 0);
      send_frame(b, par, stp, 11, -1, 0, lf);
    end

    tick(20);
    check("pending_events", q.size(), 0);
  endtask

  initial begin
    bus.PS2_CLK_IN  = 1'b1;
    bus.PS2_DATA_IN = 1'b1;
    bus.RX_ENABLE   = 1'b1;
    fork
      run_stim();
      compare_loop();
    join_any
    disable fork;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
